// File: rtl/clk_div_ctrl.sv
// Programmable divide-by-N clock controller with start/stop sequencing and a
// valid/ready ratio port; ratio changes land only on period boundaries.
module clk_div_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             r_clk,
  output logic             tick,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             r_clk_q, r_clk_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic accept;
  logic legal;
  logic wrap;
  logic running_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= CNT_W'(DEF_DIV);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      r_clk_q    <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      r_clk_q    <= r_clk_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Next-state, counter and config sequencing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    accept     = cfg_valid && !pend_q;
    legal      = (cfg_div >= CNT_W'(2));
    wrap       = (cnt_q == (div_q - CNT_W'(1)));
    cfg_err_d  = accept && !legal;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A ratio pended in the final STOP wrap cycle is applied here so the port never stalls
        if (pend_q) begin
          div_d  = pend_div_q;
          pend_d = 1'b0;
        end else if (accept && legal) begin
          div_d = cfg_div;
        end
        if (en) state_d = RUN;
      end
      RUN, STOP: begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_q) begin
            div_d  = pend_div_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (accept && legal) begin
          pend_d     = 1'b1;
          pend_div_d = cfg_div;
        end
        if (en)                  state_d = RUN;
        else if (state_q == RUN) state_d = STOP;
        else if (wrap)           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from next state so they register alongside it
    running_d = (state_d != IDLE);
    r_clk_d   = running_d && (cnt_d < (div_d >> 1));
    tick_d    = running_d && (cnt_d == '0);
  end

  assign r_clk     = r_clk_q;
  assign tick      = tick_q;
  assign cfg_err   = cfg_err_q;
  assign cfg_ready = !pend_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl: reset, run patterns, config
// handshake, stop/restart, reset with a pending ratio, odd and maximum ratios.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       r_clk;
  logic       tick;
  logic       busy;

  int errors = 0;
  int checks = 0;

  clk_div_ctrl #(.CNT_W(8), .DEF_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_div  (cfg_div),
    .cfg_ready(cfg_ready),
    .cfg_err  (cfg_err),
    .r_clk    (r_clk),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs then show the new cycle, inputs set now hit the next edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    int n;
    en = 1'b0;
    n  = 0;
    while (busy && n < 600) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL go_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({r_clk, tick, busy, cfg_ready, cfg_err} !== 5'b00010) begin
        errors++;
        $display("FAIL reset[%0d]: r_clk,tick,busy,ready,err=%b required 00010", i,
                 {r_clk, tick, busy, cfg_ready, cfg_err});
      end
      step();
    end
  endtask

  task automatic test_run();
    en = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({r_clk, tick, busy} !== {(i % 4) < 2, (i % 4) == 0, 1'b1}) begin
        errors++;
        $display("FAIL run4[%0d]: r_clk,tick,busy=%b required %b", i, {r_clk, tick, busy},
                 {(i % 4) < 2, (i % 4) == 0, 1'b1});
      end
      step();
    end
  endtask

  // Enters at cnt=0 of an N=4 period
  task automatic test_cfg_change();
    step();
    cfg_valid = 1'b1; cfg_div = 8'd6;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL cfg_ready_before: got %b required 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    for (int c = 2; c < 4; c++) begin
      checks++;
      if ({cfg_ready, r_clk, tick} !== 3'b000) begin
        errors++;
        $display("FAIL cfg_pend cnt=%0d: ready,r_clk,tick=%b required 000", c,
                 {cfg_ready, r_clk, tick});
      end
      step();
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({r_clk, tick, cfg_ready} !== {(i % 6) < 3, (i % 6) == 0, 1'b1}) begin
        errors++;
        $display("FAIL run6[%0d]: r_clk,tick,ready=%b required %b", i, {r_clk, tick, cfg_ready},
                 {(i % 6) < 3, (i % 6) == 0, 1'b1});
      end
      step();
    end
  endtask

  task automatic test_cfg_err();
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; en = 1'b1;
    step();
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_err, cfg_ready} !== 2'b11) begin
      errors++; $display("FAIL cfg_err_pulse: err,ready=%b required 11", {cfg_err, cfg_ready});
    end
    step();
    checks++;
    if ({cfg_err, cfg_ready} !== 2'b01) begin
      errors++; $display("FAIL cfg_err_clear: err,ready=%b required 01", {cfg_err, cfg_ready});
    end
    step();
    step();
    checks++;
    if ({tick, r_clk} !== 2'b11) begin
      errors++; $display("FAIL cfg_err_period: tick,r_clk=%b required 11 (period 4)", {tick, r_clk});
    end
  endtask

  // Enters at cnt=0 of an N=4 period
  task automatic test_stop_restart();
    step();
    en = 1'b0;
    step();
    checks++;
    if ({busy, r_clk} !== 2'b10) begin
      errors++; $display("FAIL stop_cnt2: busy,r_clk=%b required 10", {busy, r_clk});
    end
    step();
    checks++;
    if ({busy, r_clk, tick} !== 3'b100) begin
      errors++; $display("FAIL stop_cnt3: busy,r_clk,tick=%b required 100", {busy, r_clk, tick});
    end
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy, r_clk, tick} !== 3'b000) begin
        errors++; $display("FAIL stop_idle[%0d]: busy,r_clk,tick=%b required 000", i, {busy, r_clk, tick});
      end
      step();
    end
    en = 1'b1;
    step();
    checks++;
    if ({busy, r_clk, tick} !== 3'b111) begin
      errors++; $display("FAIL restart_first: busy,r_clk,tick=%b required 111", {busy, r_clk, tick});
    end
    step();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      checks++;
      if ({r_clk, tick, busy} !== {((i + 3) % 4) < 2, ((i + 3) % 4) == 0, 1'b1}) begin
        errors++;
        $display("FAIL no_gap[%0d]: r_clk,tick,busy=%b required %b", i, {r_clk, tick, busy},
                 {((i + 3) % 4) < 2, ((i + 3) % 4) == 0, 1'b1});
      end
      step();
    end
  endtask

  // Enters at cnt=0 of an N=4 period with en=1
  task automatic test_rst_pending();
    step();
    cfg_valid = 1'b1; cfg_div = 8'd8;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin
      errors++; $display("FAIL rst_pend_ready: got %b required 0", cfg_ready);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({r_clk, tick, busy, cfg_ready, cfg_err} !== 5'b00010) begin
      errors++;
      $display("FAIL rst_pend_outputs: r_clk,tick,busy,ready,err=%b required 00010",
               {r_clk, tick, busy, cfg_ready, cfg_err});
    end
    step();
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({r_clk, tick} !== {(i % 4) < 2, (i % 4) == 0}) begin
        errors++;
        $display("FAIL rst_pend_period[%0d]: r_clk,tick=%b required %b", i, {r_clk, tick},
                 {(i % 4) < 2, (i % 4) == 0});
      end
      step();
    end
  endtask

  // Ratio loaded in IDLE together with en; also odd and maximum ratios
  task automatic test_idle_load(input logic [7:0] n, input int cycles);
    go_idle();
    cfg_valid = 1'b1; cfg_div = n; en = 1'b1;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      checks++;
      if ({r_clk, tick} !== {(i % int'(n)) < (int'(n) / 2), (i % int'(n)) == 0}) begin
        errors++;
        $display("FAIL idle_load N=%0d [%0d]: r_clk,tick=%b required %b", n, i, {r_clk, tick},
                 {(i % int'(n)) < (int'(n) / 2), (i % int'(n)) == 0});
      end
      step();
    end
  endtask

  // Accept in the wrap cycle is pended: one more N=4 period, then N=6
  task automatic test_back_to_back();
    go_idle();
    cfg_valid = 1'b1; cfg_div = 8'd4; en = 1'b1;
    step();
    cfg_valid = 1'b0;
    step(); step(); step();
    cfg_valid = 1'b1; cfg_div = 8'd6;
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++; $display("FAIL wrap_accept_ready: got %b required 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({r_clk, tick, cfg_ready} !== {i < 2, i == 0, 1'b0}) begin
        errors++;
        $display("FAIL wrap_hold4[%0d]: r_clk,tick,ready=%b required %b", i, {r_clk, tick, cfg_ready},
                 {i < 2, i == 0, 1'b0});
      end
      step();
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({r_clk, tick, cfg_ready} !== {i < 3, i == 0, 1'b1}) begin
        errors++;
        $display("FAIL wrap_apply6[%0d]: r_clk,tick,ready=%b required %b", i, {r_clk, tick, cfg_ready},
                 {i < 3, i == 0, 1'b1});
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_cfg_change();
    test_cfg_err();
    test_stop_restart();
    test_rst_pending();
    test_idle_load(8'd5, 10);
    test_idle_load(8'd255, 510);
    test_idle_load(8'd2, 6);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
